// File: rtl/alu_muldiv_if.sv
// Purpose: request/response bundle between the pipeline and the iterative mul/div unit.
// Latency: none; this is only a grouping of wires.
// Backpressure: the requester must hold off while busy or done is high. A start in those cycles is dropped.
// Ports: start/op/A/B come from the requester. busy/done/ALUResult/zero come from the unit.
interface alu_muldiv_if #(
    parameter int n = 32
);
    logic         start;
    logic [2:0]   op;
    logic [n-1:0] A;
    logic [n-1:0] B;
    logic         busy;
    logic         done;
    logic [n-1:0] ALUResult;
    logic         zero;

    modport master (
        output start, op, A, B,
        input  busy, done, ALUResult, zero
    );

    modport slave (
        input  start, op, A, B,
        output busy, done, ALUResult, zero
    );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Purpose: iterative RV32M multiply (radix-2 shift-add) and divide (restoring), one result bit per cycle.
// Latency: done arrives n+1 cycles after the start cycle. Divide-by-zero and signed overflow finish after 1 cycle.
// Backpressure: a start is accepted only in IDLE, when busy=0 and done=0. Otherwise it is dropped, with no queueing.
// Ports: clk, and rst (async, active high). bus is a slave modport carrying start/op/A/B in and busy/done/ALUResult/zero out.
module alu_muldiv_iter #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst,
    alu_muldiv_if.slave  bus
);
    localparam int CW = $clog2(n + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t         state;
    logic [CW-1:0]  count;
    logic [2:0]     op_q;
    logic [n:0]     acc_hi;   // mul: upper product half; div: partial remainder (extra bit absorbs the shift)
    logic [n-1:0]   acc_lo;   // mul: multiplier shifting out; div: dividend shifting out / quotient shifting in
    logic [n-1:0]   opb;      // mul: multiplicand magnitude; div: divisor magnitude
    logic           neg_q;    // negate the product or quotient at the end
    logic           neg_r;    // negate the remainder at the end (sign of A)

    // Decode of the incoming request, used only in the accept cycle.
    logic           a_signed, b_signed, a_neg, b_neg;
    logic [n-1:0]   a_mag, b_mag;
    logic           div_zero, div_ovf;
    logic [n-1:0]   special_res;

    always_comb begin
        a_signed    = (bus.op == 3'b001) || (bus.op == 3'b010) ||
                      (bus.op == 3'b100) || (bus.op == 3'b110);
        b_signed    = (bus.op == 3'b001) || (bus.op == 3'b100) || (bus.op == 3'b110);
        a_neg       = a_signed && bus.A[n-1];
        b_neg       = b_signed && bus.B[n-1];
        a_mag       = a_neg ? -bus.A : bus.A;
        b_mag       = b_neg ? -bus.B : bus.B;
        div_zero    = bus.op[2] && (bus.B == '0);
        div_ovf     = bus.op[2] && !bus.op[0] &&
                      (bus.A == {1'b1, {(n-1){1'b0}}}) && (bus.B == '1);
        special_res = '0;
        if (div_zero)
            special_res = bus.op[1] ? bus.A : '1;
        else if (div_ovf)
            special_res = bus.op[1] ? '0 : bus.A;
    end

    // One iteration step, plus the result that the step would produce if it were the last one.
    logic [n:0]     sum, shifted, diff;
    logic [n:0]     hi_nx;
    logic [n-1:0]   lo_nx;
    logic [2*n-1:0] prod;
    logic [n-1:0]   quo, rem, calc_res;

    always_comb begin
        sum     = {1'b0, acc_hi[n-1:0]} + (acc_lo[0] ? {1'b0, opb} : '0);
        shifted = {acc_hi[n-1:0], acc_lo[n-1]};
        diff    = shifted - {1'b0, opb};
        if (op_q[2]) begin
            // Restoring step: a borrow out of bit n means the trial subtract went negative.
            if (!diff[n]) begin
                hi_nx = diff;
                lo_nx = {acc_lo[n-2:0], 1'b1};
            end else begin
                hi_nx = shifted;
                lo_nx = {acc_lo[n-2:0], 1'b0};
            end
        end else begin
            hi_nx = {1'b0, sum[n:1]};
            lo_nx = {sum[0], acc_lo[n-1:1]};
        end

        prod = {hi_nx[n-1:0], lo_nx};
        if (neg_q)
            prod = -prod;
        quo = neg_q ? -lo_nx : lo_nx;
        rem = neg_r ? -hi_nx[n-1:0] : hi_nx[n-1:0];

        case (op_q)
            3'b000:                 calc_res = prod[n-1:0];
            3'b001, 3'b010, 3'b011: calc_res = prod[2*n-1:n];
            3'b100, 3'b101:         calc_res = quo;
            default:                calc_res = rem;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            count         <= '0;
            op_q          <= '0;
            acc_hi        <= '0;
            acc_lo        <= '0;
            opb           <= '0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.ALUResult <= '0;
            bus.zero      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        op_q  <= bus.op;
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        if (div_zero || div_ovf) begin
                            bus.ALUResult <= special_res;
                            bus.zero      <= (special_res == '0);
                            bus.done      <= 1'b1;
                            state         <= FIN;
                        end else begin
                            acc_hi   <= '0;
                            // Divide shifts the dividend out of acc_lo. Multiply shifts the multiplier out.
                            acc_lo   <= bus.op[2] ? a_mag : b_mag;
                            opb      <= bus.op[2] ? b_mag : a_mag;
                            count    <= CW'(n);
                            bus.busy <= 1'b1;
                            state    <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_hi <= hi_nx;
                    acc_lo <= lo_nx;
                    count  <= count - 1'b1;
                    if (count == CW'(1)) begin
                        // The last iteration registers its result directly, so done lines up with FIN.
                        bus.ALUResult <= calc_res;
                        bus.zero      <= (calc_res == '0);
                        bus.busy      <= 1'b0;
                        bus.done      <= 1'b1;
                        state         <= FIN;
                    end
                end
                FIN: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_muldiv_iter.sv
module tb_alu_muldiv_iter;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    alu_muldiv_if #(.n(32)) bus ();

    alu_muldiv_iter #(.n(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model built from the RISC-V M-extension rules using 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (op)
            3'd0: begin p = ua * ub; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
            3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        return op[2] && ((b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    task automatic wait_idle();
        int guard = 0;
        @(negedge clk);
        while ((bus.busy || bus.done) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("idle_timeout", 1, 0);
    endtask

    // Issue one request, scramble the inputs after acceptance, and check the result and the latency.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp;
        int lat;
        int exp_lat;
        exp     = model(op, a, b);
        exp_lat = is_special(op, a, b) ? 1 : 33;
        wait_idle();
        bus.start = 1'b1;
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
            if (lat == 1) begin
                bus.start = 1'b0;
                bus.op    = 3'($urandom);
                bus.A     = $urandom;
                bus.B     = $urandom;
                check({tag, "_busy1"}, bus.busy, exp_lat != 1);
            end
            if (bus.busy && bus.done) check({tag, "_busy_and_done"}, 1, 0);
        end while (!bus.done && lat < 100);
        check({tag, "_res"}, bus.ALUResult, exp);
        check({tag, "_zero"}, bus.zero, exp == 0);
        check({tag, "_lat"}, lat, exp_lat);
    endtask

    initial begin
        logic [31:0] expq[$];
        logic [31:0] last, a, b;
        logic [2:0]  op;
        bit   have;
        int   acc_cnt, done_cnt, sel;

        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.A     = '0;
        bus.B     = '0;
        rst       = 1'b1;
        #1;
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_res",  bus.ALUResult, 0);
        check("reset_zero", bus.zero, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset in the middle of an iteration must clear the outputs without waiting for a clock edge.
        run_op("pre_rst", 3'd3, 32'h1234_5678, 32'h9ABC_DEF0);
        wait_idle();
        bus.start = 1'b1; bus.op = 3'd0; bus.A = 32'h0000_0007; bus.B = 32'h0000_0009;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        check("mid_busy_before_rst", bus.busy, 1);
        rst = 1'b1;
        #1;
        check("rst_async_busy", bus.busy, 0);
        check("rst_async_done", bus.done, 0);
        check("rst_async_res",  bus.ALUResult, 0);
        @(negedge clk);
        rst = 1'b0;
        run_op("after_rst", 3'd0, 32'd7, 32'd9);

        run_op("mul_ff_2",    3'd0, 32'hFFFF_FFFF, 32'h2);
        run_op("mulhu_ff_2",  3'd3, 32'hFFFF_FFFF, 32'h2);
        run_op("mulh_m1",     3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulhsu_m1",   3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mul_zero",    3'd0, 32'h0, 32'h1234_5678);
        run_op("div_m7_2",    3'd4, 32'hFFFF_FFF9, 32'h2);
        run_op("rem_m7_2",    3'd6, 32'hFFFF_FFF9, 32'h2);
        run_op("divu_20_6",   3'd5, 32'd20, 32'd6);
        run_op("remu_20_6",   3'd7, 32'd20, 32'd6);
        run_op("divu_by0",    3'd5, 32'd5, 32'd0);
        run_op("rem_by0",     3'd6, 32'd5, 32'd0);
        run_op("div_ovf",     3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("rem_ovf",     3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div_min_m2",  3'd4, 32'h8000_0000, 32'hFFFF_FFFE);

        for (int i = 0; i < 30; i++) begin
            op  = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) b = 32'h0;
            if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (sel == 2) b = 32'($urandom_range(1, 15));
            run_op($sformatf("rand%0d", i), op, a, b);
        end

        // start held high with operands changing every cycle. Only requests seen while idle may count.
        wait_idle();
        acc_cnt  = 0;
        done_cnt = 0;
        have     = 0;
        last     = '0;
        for (int c = 0; c < 110; c++) begin
            if (c > 0) @(negedge clk);
            if (bus.busy && bus.done) check("hs_busy_and_done", 1, 0);
            if (bus.done) begin
                done_cnt++;
                if (expq.size() == 0) check("hs_spurious_done", 1, 0);
                else check("hs_res", bus.ALUResult, expq.pop_front());
                last = bus.ALUResult;
                have = 1;
            end else if (have) begin
                if (bus.ALUResult !== last) check("hs_hold", bus.ALUResult, last);
            end
            bus.start = (c < 45);
            bus.op    = 3'($urandom_range(0, 7));
            bus.A     = $urandom;
            bus.B     = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            if (bus.start && !bus.busy && !bus.done) begin
                expq.push_back(model(bus.op, bus.A, bus.B));
                acc_cnt++;
            end
        end
        check("hs_all_done", done_cnt, acc_cnt);
        check("hs_some_accepted", acc_cnt >= 2, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
